// File: rtl/riscv_ex_pkg.sv
// Shared execute-stage definitions: ALUop codes, FSM encoding and bus payloads.
// The decoder imports this package as well so opcode values stay in one place.
package riscv_ex_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 5;
  localparam int unsigned RDW  = 5;

  localparam logic [OPW-1:0] OP_ADD   = 5'd0;
  localparam logic [OPW-1:0] OP_SUB   = 5'd1;
  localparam logic [OPW-1:0] OP_XOR   = 5'd2;
  localparam logic [OPW-1:0] OP_OR    = 5'd3;
  localparam logic [OPW-1:0] OP_AND   = 5'd4;
  localparam logic [OPW-1:0] OP_SLL   = 5'd5;
  localparam logic [OPW-1:0] OP_SRL   = 5'd6;
  localparam logic [OPW-1:0] OP_SRA   = 5'd7;
  localparam logic [OPW-1:0] OP_SLT   = 5'd8;
  localparam logic [OPW-1:0] OP_SLTU  = 5'd9;
  localparam logic [OPW-1:0] OP_ADDI  = 5'd10;
  localparam logic [OPW-1:0] OP_XORI  = 5'd11;
  localparam logic [OPW-1:0] OP_ORI   = 5'd12;
  localparam logic [OPW-1:0] OP_ANDI  = 5'd13;
  localparam logic [OPW-1:0] OP_SLLI  = 5'd14;
  localparam logic [OPW-1:0] OP_SRLI  = 5'd15;
  localparam logic [OPW-1:0] OP_SRAI  = 5'd16;
  localparam logic [OPW-1:0] OP_SLTI  = 5'd17;
  localparam logic [OPW-1:0] OP_SLTIU = 5'd18;
  localparam logic [OPW-1:0] OP_SW    = 5'd20;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } ex_state_t;

  // Latched copy of the ID/EX register
  typedef struct packed {
    logic [XLEN-1:0] operand1;
    logic [XLEN-1:0] operand2;
    logic [OPW-1:0]  alu_op;
    logic            mem_read;
    logic            mem_write;
    logic [RDW-1:0]  rd;
  } id_ex_t;

  // EX/MEM bundle contents
  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [RDW-1:0]  rd;
    logic            reg_we;
    logic            mem_read;
    logic            mem_write;
    logic            illegal;
  } ex_mem_t;

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX consumer and EX/MEM producer signals of the execute stage.
interface execute_stage_if;
  import riscv_ex_pkg::*;

  logic            i_dec_ins_ready;
  logic [XLEN-1:0] i_operand1;
  logic [XLEN-1:0] i_operand2;
  logic [OPW-1:0]  i_ALUop;
  logic            i_mem_read;
  logic            i_mem_write;
  logic [RDW-1:0]  i_rd;
  logic            i_mem_ready;
  logic            o_flush;
  logic            o_ex_valid;
  logic [XLEN-1:0] o_result;
  logic [XLEN-1:0] o_store_data;
  logic [RDW-1:0]  o_rd;
  logic            o_reg_we;
  logic            o_mem_read;
  logic            o_mem_write;
  logic            o_illegal;
  logic            o_busy;

  modport slave (
    input  i_dec_ins_ready, i_operand1, i_operand2, i_ALUop, i_mem_read, i_mem_write, i_rd,
    input  i_mem_ready,
    output o_flush, o_ex_valid, o_result, o_store_data, o_rd, o_reg_we,
    output o_mem_read, o_mem_write, o_illegal, o_busy
  );

  modport master (
    output i_dec_ins_ready, i_operand1, i_operand2, i_ALUop, i_mem_read, i_mem_write, i_rd,
    output i_mem_ready,
    input  o_flush, o_ex_valid, o_result, o_store_data, o_rd, o_reg_we,
    input  o_mem_read, o_mem_write, o_illegal, o_busy
  );

endinterface

// File: rtl/execute_stage_alu_core.sv
// Combinational ALU: I-type ops sign-extend the 12-bit immediate held in op2.
module alu_core
  import riscv_ex_pkg::*;
(
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [OPW-1:0]  alu_op,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] b;
  logic [4:0]      shamt;
  logic            is_itype;

  always_comb begin
    imm      = {{(XLEN-12){op2[11]}}, op2[11:0]};
    is_itype = (alu_op >= OP_ADDI) && (alu_op <= OP_SLTIU);
    b        = is_itype ? imm : op2;
    shamt    = b[4:0];
    result   = '0;
    illegal  = 1'b0;
    case (alu_op)
      OP_ADD,  OP_ADDI:  result = op1 + b;
      OP_SUB:            result = op1 - b;
      OP_XOR,  OP_XORI:  result = op1 ^ b;
      OP_OR,   OP_ORI:   result = op1 | b;
      OP_AND,  OP_ANDI:  result = op1 & b;
      OP_SLL,  OP_SLLI:  result = op1 << shamt;
      OP_SRL,  OP_SRLI:  result = op1 >> shamt;
      OP_SRA,  OP_SRAI:  result = XLEN'($signed(op1) >>> shamt);
      OP_SLT,  OP_SLTI:  result = XLEN'($signed(op1) < $signed(b));
      OP_SLTU, OP_SLTIU: result = XLEN'(op1 < b);
      OP_SW:             result = '0;
      default:           illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: latches the ID/EX register, computes, presents an EX/MEM bundle
// under valid/ready and returns a one-cycle flush pulse to release the decoder.
module execute_stage
  import riscv_ex_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  execute_stage_if.slave  ex
);

  ex_state_t       state_q, state_nxt;
  id_ex_t          in_q, in_nxt;
  ex_mem_t         out_q, out_nxt, bundle_c;
  logic            valid_q, valid_nxt;
  logic            flush_q, flush_nxt;
  logic            busy_q;
  logic [XLEN-1:0] alu_result;
  logic            alu_illegal;

  alu_core u_alu (
    .op1     (in_q.operand1),
    .op2     (in_q.operand2),
    .alu_op  (in_q.alu_op),
    .result  (alu_result),
    .illegal (alu_illegal)
  );

  // Bundle formation; stores carry their address in rd and write no register
  always_comb begin
    bundle_c         = '0;
    bundle_c.illegal = alu_illegal;
    if (!alu_illegal) begin
      if (in_q.alu_op == OP_SW) begin
        bundle_c.result     = XLEN'(in_q.rd);
        bundle_c.store_data = in_q.operand2;
        bundle_c.mem_write  = in_q.mem_write;
      end else begin
        bundle_c.result   = alu_result;
        bundle_c.rd       = in_q.rd;
        bundle_c.reg_we   = (in_q.rd != '0);
        bundle_c.mem_read = in_q.mem_read;
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    in_nxt    = in_q;
    out_nxt   = out_q;
    valid_nxt = valid_q;
    flush_nxt = flush_q;
    case (state_q)
      ST_IDLE: begin
        if (ex.i_dec_ins_ready) begin
          in_nxt.operand1  = ex.i_operand1;
          in_nxt.operand2  = ex.i_operand2;
          in_nxt.alu_op    = ex.i_ALUop;
          in_nxt.mem_read  = ex.i_mem_read;
          in_nxt.mem_write = ex.i_mem_write;
          in_nxt.rd        = ex.i_rd;
          state_nxt        = ST_EXEC;
        end
      end
      ST_EXEC: begin
        out_nxt   = bundle_c;
        valid_nxt = 1'b1;
        state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (ex.i_mem_ready) begin
          valid_nxt = 1'b0;
          flush_nxt = 1'b1;
          state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        flush_nxt = 1'b0;
        // Wait for the decoder to drop its level so it is never captured twice
        if (!ex.i_dec_ins_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      in_q    <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      in_q    <= in_nxt;
      out_q   <= out_nxt;
      valid_q <= valid_nxt;
      flush_q <= flush_nxt;
      busy_q  <= (state_nxt != ST_IDLE);
    end
  end

  assign ex.o_flush      = flush_q;
  assign ex.o_ex_valid   = valid_q;
  assign ex.o_result     = out_q.result;
  assign ex.o_store_data = out_q.store_data;
  assign ex.o_rd         = out_q.rd;
  assign ex.o_reg_we     = out_q.reg_we;
  assign ex.o_mem_read   = out_q.mem_read;
  assign ex.o_mem_write  = out_q.mem_write;
  assign ex.o_illegal    = out_q.illegal;
  assign ex.o_busy       = busy_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage with hand-computed expected bundles.
module tb_execute_stage;
  import riscv_ex_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  execute_stage_if bus ();

  execute_stage u_dut (
    .clk (clk),
    .rst (rst),
    .ex  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_bundle(input string tag, input logic [31:0] e_res, input logic [31:0] e_sd,
                              input logic [4:0] e_rd, input logic e_we, input logic e_mr,
                              input logic e_mw, input logic e_ill);
    check({tag, ".valid"}, 32'(bus.o_ex_valid), 32'd1);
    check({tag, ".result"}, bus.o_result, e_res);
    check({tag, ".store_data"}, bus.o_store_data, e_sd);
    check({tag, ".rd"}, 32'(bus.o_rd), 32'(e_rd));
    check({tag, ".reg_we"}, 32'(bus.o_reg_we), 32'(e_we));
    check({tag, ".mem_read"}, 32'(bus.o_mem_read), 32'(e_mr));
    check({tag, ".mem_write"}, 32'(bus.o_mem_write), 32'(e_mw));
    check({tag, ".illegal"}, 32'(bus.o_illegal), 32'(e_ill));
    check({tag, ".flush"}, 32'(bus.o_flush), 32'd0);
  endtask

  // One full transaction: capture, bundle, optional stall, flush, optional extra hold of ready
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] op, input logic mr, input logic mw, input logic [4:0] rd,
                        input int stall, input int hold,
                        input logic [31:0] e_res, input logic [31:0] e_sd, input logic [4:0] e_rd,
                        input logic e_we, input logic e_mr, input logic e_mw, input logic e_ill);
    @(negedge clk);
    bus.i_operand1      = a;
    bus.i_operand2      = b;
    bus.i_ALUop         = op;
    bus.i_mem_read      = mr;
    bus.i_mem_write     = mw;
    bus.i_rd            = rd;
    bus.i_dec_ins_ready = 1'b1;
    bus.i_mem_ready     = (stall == 0);
    @(posedge clk); #1;
    check({tag, ".lat_valid"}, 32'(bus.o_ex_valid), 32'd0);
    check({tag, ".lat_busy"}, 32'(bus.o_busy), 32'd1);
    @(posedge clk); #1;
    check_bundle(tag, e_res, e_sd, e_rd, e_we, e_mr, e_mw, e_ill);
    // Scramble the decoder side while stalled; the latched copy must not move
    bus.i_operand1 = ~a;
    bus.i_operand2 = ~b;
    bus.i_rd       = ~rd;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check_bundle({tag, ".stall"}, e_res, e_sd, e_rd, e_we, e_mr, e_mw, e_ill);
    end
    @(negedge clk);
    bus.i_mem_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, ".flush_hi"}, 32'(bus.o_flush), 32'd1);
    check({tag, ".valid_lo"}, 32'(bus.o_ex_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, ".flush_1cyc"}, 32'(bus.o_flush), 32'd0);
    check({tag, ".rel_busy"}, 32'(bus.o_busy), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, ".hold_valid"}, 32'(bus.o_ex_valid), 32'd0);
      check({tag, ".hold_flush"}, 32'(bus.o_flush), 32'd0);
      check({tag, ".hold_busy"}, 32'(bus.o_busy), 32'd1);
    end
    @(negedge clk);
    bus.i_dec_ins_ready = 1'b0;
    bus.i_mem_ready     = 1'b0;
    @(posedge clk); #1;
    check({tag, ".idle_busy"}, 32'(bus.o_busy), 32'd0);
    @(posedge clk); #1;
    check({tag, ".no_recapture"}, 32'(bus.o_ex_valid), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"}, 32'(bus.o_ex_valid), 32'd0);
    check({tag, ".flush"}, 32'(bus.o_flush), 32'd0);
    check({tag, ".result"}, bus.o_result, 32'd0);
    check({tag, ".store_data"}, bus.o_store_data, 32'd0);
    check({tag, ".rd"}, 32'(bus.o_rd), 32'd0);
    check({tag, ".flags"}, {28'd0, bus.o_reg_we, bus.o_mem_read, bus.o_mem_write, bus.o_illegal}, 32'd0);
    check({tag, ".busy"}, 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    n_checks            = 0;
    n_fail              = 0;
    rst                 = 1'b0;
    bus.i_dec_ins_ready = 1'b0;
    bus.i_operand1      = '0;
    bus.i_operand2      = '0;
    bus.i_ALUop         = '0;
    bus.i_mem_read      = 1'b0;
    bus.i_mem_write     = 1'b0;
    bus.i_rd            = '0;
    bus.i_mem_ready     = 1'b0;
    #22;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    //      tag      op1           op2           op  mr mw rd   st hd  result        sdata         rd  we mr mw ill
    run_op("add",   32'd5,        32'd7,        5'd0,  0, 0, 5'd3, 0, 0, 32'd12,       32'd0,        5'd3, 1, 0, 0, 0);
    run_op("sub",   32'd3,        32'd5,        5'd1,  0, 0, 5'd4, 0, 0, 32'hFFFFFFFE, 32'd0,        5'd4, 1, 0, 0, 0);
    run_op("addi",  32'd10,       32'h00000FFF, 5'd10, 0, 0, 5'd6, 0, 0, 32'd9,        32'd0,        5'd6, 1, 0, 0, 0);
    run_op("srai",  32'h80000000, 32'h00000404, 5'd16, 0, 0, 5'd1, 0, 0, 32'hF8000000, 32'd0,        5'd1, 1, 0, 0, 0);
    run_op("sltu",  32'd1,        32'hFFFFFFFF, 5'd9,  0, 0, 5'd2, 0, 0, 32'd1,        32'd0,        5'd2, 1, 0, 0, 0);
    run_op("slt",   32'hFFFFFFFF, 32'd1,        5'd8,  0, 0, 5'd2, 0, 0, 32'd1,        32'd0,        5'd2, 1, 0, 0, 0);
    run_op("slli",  32'd1,        32'h0000001F, 5'd14, 0, 0, 5'd9, 0, 0, 32'h80000000, 32'd0,        5'd9, 1, 0, 0, 0);
    run_op("add_x0",32'd1,        32'd1,        5'd0,  0, 0, 5'd0, 0, 0, 32'd2,        32'd0,        5'd0, 0, 0, 0, 0);
    run_op("load",  32'h00001000, 32'h00000FF8, 5'd10, 1, 0, 5'd7, 0, 0, 32'h00000FF8, 32'd0,        5'd7, 1, 1, 0, 0);
    run_op("sw",    32'h12345678, 32'hDEADBEEF, 5'd20, 0, 1, 5'd5, 0, 0, 32'd5,        32'hDEADBEEF, 5'd0, 0, 0, 1, 0);
    run_op("bp",    32'hA5A5A5A5, 32'h0F0F0F0F, 5'd2,  0, 0, 5'd8, 3, 2, 32'hAAAAAAAA, 32'd0,        5'd8, 1, 0, 0, 0);
    run_op("ill19", 32'd5,        32'd7,        5'd19, 0, 0, 5'd3, 0, 0, 32'd0,        32'd0,        5'd0, 0, 0, 0, 1);

    // Reset while the bundle is held: everything clears immediately, no flush
    @(negedge clk);
    bus.i_operand1      = 32'd20;
    bus.i_operand2      = 32'd22;
    bus.i_ALUop         = 5'd0;
    bus.i_rd            = 5'd11;
    bus.i_dec_ins_ready = 1'b1;
    bus.i_mem_ready     = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_hold.pre_valid", 32'(bus.o_ex_valid), 32'd1);
    check("rst_hold.pre_result", bus.o_result, 32'd42);
    rst = 1'b0;
    #1;
    check_all_zero("rst_hold");
    bus.i_dec_ins_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_hold.post_busy", 32'(bus.o_busy), 32'd0);
    run_op("after_rst", 32'd100, 32'd1, 5'd4, 0, 0, 5'd12, 0, 0, 32'd0, 32'd0, 5'd12, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
